// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART transmit and receive paths.
//   - FSM state encoding (3 bits wide, same width as the receiver's state
//     register, so both sides can share debug tooling).
//   - Default bit period and frame shape constants.
// No ports; imported by the transmit interface, FIFO and top level.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default clock cycles per bit period.
    localparam int DEFAULT_CLKS_PER_BIT = 1250;

    // Frame shape: 8 data bits, 1 stop bit, no parity.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Framing FSM state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;

endpackage

// File: rtl/uart8n1_tx_buf_if.sv
// -----------------------------------------------------------------------------
// uart8n1_tx_buf_if
// Byte write port of the buffered UART transmitter (valid/ready handshake).
//   txDv     write strobe from the producer
//   txByte   byte to queue, sampled when txDv && txReady at a rising edge
//   txReady  transmitter FIFO has a free slot
// Modports:
//   master - producer side (drives txDv/txByte, observes txReady)
//   slave  - transmitter side (observes txDv/txByte, drives txReady)
// -----------------------------------------------------------------------------
interface uart8n1_tx_buf_if;
    import uart_pkg::*;

    logic                 txDv;
    logic [DATA_BITS-1:0] txByte;
    logic                 txReady;

    modport master (
        output txDv,
        output txByte,
        input  txReady
    );

    modport slave (
        input  txDv,
        input  txByte,
        output txReady
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Circular byte FIFO feeding the UART framing FSM.
// Ports:
//   clk, rst      clock and synchronous active-high reset (flushes pointers/count)
//   wrEn, wrData  push request and data; ignored while full
//   full          no free slot (write side must hold off)
//   rdEn          pop request; ignored while empty
//   rdData        head-of-queue byte, valid whenever empty is low
//   empty         no stored byte
// Parameter DEPTH: number of slots, power of 2, at least 2.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrEn,
    input  logic [DATA_BITS-1:0] wrData,
    output logic                 full,
    input  logic                 rdEn,
    output logic [DATA_BITS-1:0] rdData,
    output logic                 empty
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic w_push;
    logic w_pop;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);

    // A push while full is dropped even if a pop frees a slot on the same
    // edge: the producer saw txReady low, so it must not count as accepted.
    assign w_push = wrEn && !full;
    assign w_pop  = rdEn && !empty;

    // The FSM latches the head byte on the same edge it pops, so the head
    // has to be readable combinationally (show-ahead); a handful of slots
    // maps onto distributed RAM rather than a registered-read block RAM.
    assign rdData = r_mem[r_rd_ptr];

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart8n1_tx_buf.sv
// -----------------------------------------------------------------------------
// uart8n1_tx_buf
// Buffered 8N1 UART transmitter: bytes arrive over a valid/ready port into a
// small FIFO and are serialised LSB first with one start and one stop bit.
// Back-to-back frames leave no idle gap on the line.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset (aborts any frame, flushes FIFO)
//   en      when low no new frame starts; a frame in flight completes
//   wr      byte write port (txDv/txByte in, txReady out)
//   txOut   registered serial line, idle high
//   txDone  one-cycle pulse during the last cycle of each stop bit
//   isIdle  controller in Idle with an empty FIFO
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, at least 2
//   FIFO_DEPTH    FIFO slots, power of 2, at least 2
// -----------------------------------------------------------------------------
module uart8n1_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    uart8n1_tx_buf_if.slave        wr,
    output logic                   txOut,
    output logic                   txDone,
    output logic                   isIdle
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    // txDone is registered, so it is set one cycle early to land on the
    // final cycle of the stop bit.
    localparam logic [CW-1:0] CNT_DONE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_txOut;
    logic                 r_txDone;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic                 w_pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wr.txDv),
        .wrData (wr.txByte),
        .full   (w_fifo_full),
        .rdEn   (w_pop),
        .rdData (w_rd_data),
        .empty  (w_fifo_empty)
    );

    assign wr.txReady = !w_fifo_full;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_stop_end = (r_state == ST_STOP) && w_bit_end && (r_idx == STOP_LAST);

    // A new frame starts either from Idle or straight out of the final stop
    // cycle; the latter is what keeps consecutive frames gap-free.
    assign w_pop = en && !w_fifo_empty &&
                   ((r_state == ST_IDLE) || w_stop_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_txOut  <= 1'b1;
            r_txDone <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_txOut <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_rd_data;
                        r_txOut <= 1'b0;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txOut <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
                            r_txOut <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_txOut <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (!w_bit_end) begin
                        r_cnt <= r_cnt + 1'b1;
                        if ((r_cnt == CNT_DONE) && (r_idx == STOP_LAST)) begin
                            r_txDone <= 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                        if (r_idx != STOP_LAST) begin
                            // Further stop bits (only when STOP_BITS > 1).
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_idx <= '0;
                            if (w_pop) begin
                                r_shift <= w_rd_data;
                                r_txOut <= 1'b0;
                                r_state <= ST_START;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_txOut <= 1'b1;
                end
            endcase
        end
    end

    assign txOut  = r_txOut;
    assign txDone = r_txDone;
    assign isIdle = (r_state == ST_IDLE) && w_fifo_empty;

endmodule

// File: tb/tb_uart8n1_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart8n1_tx_buf
// Self-checking bench for uart8n1_tx_buf with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Bytes expected on the line are queued when the bench drives an accepted
// write; a behavioural 8N1 receiver decodes txOut and pops the queue.
// -----------------------------------------------------------------------------
module tb_uart8n1_tx_buf;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic       en;
        logic       dv;
        logic [7:0] data;
        logic       exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic txOut;
    logic txDone;
    logic isIdle;

    uart8n1_tx_buf_if wr_if ();

    uart8n1_tx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .wr     (wr_if.slave),
        .txOut  (txOut),
        .txDone (txDone),
        .isIdle (isIdle)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q [$];
    int         starts [$];
    vec_t       vecs [12];

    // Receiver model state
    bit         mon_busy = 1'b0;
    int         mon_n    = 0;
    logic [9:0] mon_bits;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void frame_end();
        logic [7:0] e;
        check("start_bit", 32'(mon_bits[0]), 32'd0);
        check("stop_bit", 32'(mon_bits[9]), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected none", mon_bits[8:1]);
        end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(mon_bits[8:1]), 32'(e));
            $display("frame byte %02h decoded at cycle %0d", mon_bits[8:1], cyc);
        end
    endfunction

    // Advance to the next falling edge and run the line receiver model.
    task automatic tick();
        logic exp_done;
        @(negedge clk);
        cyc++;
        if (rst) begin
            mon_busy = 1'b0;
            return;
        end
        if (!mon_busy && txOut === 1'b0) begin
            mon_busy = 1'b1;
            mon_n    = 0;
            starts.push_back(cyc);
        end
        exp_done = mon_busy && (mon_n == FRAME - 1);
        if (txDone === 1'b1) done_cnt++;
        if (txDone !== 1'b0 || exp_done) begin
            check("txDone_timing", 32'(txDone), 32'(exp_done));
        end
        if (mon_busy) begin
            if (mon_n % CPB == CPB / 2) mon_bits[mon_n / CPB] = txOut;
            if (mon_n == FRAME - 1) begin
                mon_busy = 1'b0;
                frame_end();
            end else begin
                mon_n++;
            end
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            en            = vecs[i].en;
            wr_if.txDv    = vecs[i].dv;
            wr_if.txByte  = vecs[i].data;
            check($sformatf("txReady_vec%0d", i), 32'(wr_if.txReady), 32'(vecs[i].exp_ready));
            if (vecs[i].dv && vecs[i].exp_ready) exp_q.push_back(vecs[i].data);
            $display("vec %0d en=%0b dv=%0b byte=%02h ready=%0b", i, vecs[i].en,
                     vecs[i].dv, vecs[i].data, wr_if.txReady);
            tick();
        end
        wr_if.txDv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_if.txDv   = 1'b1;
        wr_if.txByte = b;
        check("txReady_wr", 32'(wr_if.txReady), 32'd1);
        exp_q.push_back(b);
        $display("write byte %02h at cycle %0d", b, cyc);
        tick();
        wr_if.txDv = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while (!(isIdle === 1'b1 && !mon_busy) && k < budget) begin
            tick();
            k++;
        end
        check("quiet_timeout", 32'(isIdle === 1'b1 && !mon_busy), 32'd1);
    endtask

    // Wait until the receiver model is about to process frame cycle n.
    task automatic wait_bit(input int n, input int budget);
        int k = 0;
        while (!(mon_busy && mon_n == n) && k < budget) begin
            tick();
            k++;
        end
        check("wait_bit_timeout", 32'(mon_busy && mon_n == n), 32'd1);
    endtask

    initial begin
        int         s0;
        int         d0;
        bit         all_high;
        logic [9:0] f55;

        // en, dv, data, txReady expected before this write
        vecs[0]  = '{1'b1, 1'b1, 8'hA3, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'h0F, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'h11, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'h77, 1'b0};  // FIFO full: must be dropped
        vecs[6]  = '{1'b0, 1'b1, 8'h12, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h34, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h56, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h78, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0};  // full with no pop while en=0
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0};

        wr_if.txDv   = 1'b0;
        wr_if.txByte = 8'h00;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_txOut", 32'(txOut), 32'd1);
        check("reset_txDone", 32'(txDone), 32'd0);
        check("reset_isIdle", 32'(isIdle), 32'd1);
        check("reset_txReady", 32'(wr_if.txReady), 32'd1);

        // Test 1: single 0x55 frame, exact waveform
        f55 = {1'b1, 8'h55, 1'b0};
        d0  = done_cnt;
        write_byte(8'h55);
        check("t1_txOut_after_accept", 32'(txOut), 32'd1);
        check("t1_isIdle_after_accept", 32'(isIdle), 32'd0);
        tick();
        for (int i = 0; i < FRAME; i++) begin
            check($sformatf("t1_wave%0d", i), 32'(txOut), 32'(f55[i / CPB]));
            tick();
        end
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        wait_quiet(20);
        check("t1_isIdle_end", 32'(isIdle), 32'd1);

        // Tests 2/3: burst of writes, contiguous frames, overflow write dropped
        s0 = starts.size();
        apply_rows(0, 5);
        check("t3_txReady_hold", 32'(wr_if.txReady), 32'd0);
        wait_quiet(6 * FRAME + 50);
        check("t2_frame_count", 32'(starts.size() - s0), 32'd5);
        if (starts.size() >= s0 + 5) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("t2_gap%0d", j), 32'(starts[s0+j+1] - starts[s0+j]), 32'(FRAME));
            end
        end

        // Test 4: writes with en=0 stay queued, then start on the next edge
        s0 = starts.size();
        apply_rows(6, 11);
        all_high = 1'b1;
        for (int i = 0; i < 12; i++) begin
            all_high &= (txOut === 1'b1);
            tick();
        end
        check("t4_line_high", 32'(all_high), 32'd1);
        check("t4_isIdle_low", 32'(isIdle), 32'd0);
        check("t4_no_start", 32'(starts.size() - s0), 32'd0);
        en = 1'b1;
        tick();
        check("t4_start_next_edge", 32'(txOut), 32'd0);
        wait_quiet(5 * FRAME + 50);

        // Test 5: en drops during data bit 3 of 0xC6 with 0x3C queued
        write_byte(8'hC6);
        write_byte(8'h3C);
        d0 = done_cnt;
        wait_bit(4 * CPB + 2, 3 * FRAME);
        en = 1'b0;
        s0 = starts.size();
        while (mon_busy && cyc < 100000) tick();
        check("t5_done_once", 32'(done_cnt - d0), 32'd1);
        all_high = 1'b1;
        for (int i = 0; i < 30; i++) begin
            all_high &= (txOut === 1'b1);
            tick();
        end
        check("t5_line_high", 32'(all_high), 32'd1);
        check("t5_no_start", 32'(starts.size() - s0), 32'd0);
        check("t5_isIdle_low", 32'(isIdle), 32'd0);
        en = 1'b1;
        tick();
        check("t5_resume", 32'(txOut), 32'd0);
        wait_quiet(2 * FRAME + 50);

        // Test 6: reset during data bit 5 with two bytes queued
        write_byte(8'h81);
        write_byte(8'h42);
        write_byte(8'h99);
        wait_bit(6 * CPB + 2, 3 * FRAME);
        rst = 1'b1;
        s0  = starts.size();
        d0  = done_cnt;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t6_txOut", 32'(txOut), 32'd1);
        check("t6_txDone", 32'(txDone), 32'd0);
        check("t6_txReady", 32'(wr_if.txReady), 32'd1);
        check("t6_isIdle", 32'(isIdle), 32'd1);
        all_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            all_high &= (txOut === 1'b1);
            tick();
        end
        check("t6_line_high", 32'(all_high), 32'd1);
        check("t6_no_frames", 32'(starts.size() - s0), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
